// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit CLA slice reused once per nibble, LSB first.
// Result valid NIB cycles after accept; result held in DONE until out_ready, operands refused meanwhile.

module cla4_slice (
  input  logic       cin,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [4:0] out
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = in1 & in2;
  assign w_p = in1 ^ in2;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign out = {w_c[4], w_p ^ w_c[3:0]};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [3:0]       w_in1;
  logic [3:0]       w_in2;
  logic [4:0]       w_out;
  logic             w_last;

  assign w_in1  = r_a[4*r_idx +: 4];
  assign w_in2  = r_b[4*r_idx +: 4];
  assign w_last = (r_idx == IDXW'(NIB - 1));

  cla4_slice u_slice (
    .cin (r_carry),
    .in1 (w_in1),
    .in2 (w_in2),
    .out (w_out)
  );

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[4*r_idx +: 4] <= w_out[3:0];
          r_carry             <= w_out[4];
          r_idx               <= r_idx + 1'b1;
          if (w_last) begin
            r_cout      <= w_out[4];
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_out[3] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): queue scoreboard fed at accept, drained by a monitor.

module tb_nibble_serial_adder_ctrl;
  localparam int W      = 16;
  localparam int NIB    = W / 4;
  localparam int ACC_IV = NIB + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int n_pops = 0;
  logic [17:0] exp_q[$];

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {cout, ovf, sum} from plain 17-bit and signed integer arithmetic.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [16:0] u;
    int          sx;
    int          sy;
    int          sr;
    logic        c;
    logic        v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      u  = {1'b0, x} - {1'b0, y};
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y};
      c  = u[16];
      sr = sx + sy;
    end
    v = (sr > 32767) || (sr < -32768);
    return {c, v, u[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Drive one operand set; returns accept time and how many cycles in_ready stayed low.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       output time acc_t, output int waits);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    sub = isub;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    waits = n;
    acc_t = 0;
    if (!in_ready) begin
      timeout_fail("accept");
    end else begin
      exp_q.push_back(model(ia, ib, isub));
      @(posedge clk);
      acc_t = $time;
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) timeout_fail("wait_idle");
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result transfer is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_result: got sum=0x%0h with no outstanding operation", sum);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        n_pops++;
        check("result", {14'b0, cout, ovf, sum}, {14'b0, e});
      end
    end
  end

  initial begin
    time         t_acc;
    time         t_prev;
    int          waits;
    int          pops_before;
    int          n;
    logic [17:0] snap;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_outputs", {15'b0, cout, ovf, sum}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Plain add with latency and in_ready profile.
    issue(16'h00FF, 16'h0001, 1'b0, t_acc, waits);
    for (int j = 0; j <= NIB; j++) begin
      @(negedge clk);
      check("lat_out_valid", 32'(out_valid), (j == NIB) ? 1 : 0);
      check("lat_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    check("back_to_idle", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Carry, overflow and subtract corners.
    issue(16'hFFFF, 16'h0001, 1'b0, t_acc, waits);
    issue(16'h7FFF, 16'h0001, 1'b0, t_acc, waits);
    issue(16'h0005, 16'h0007, 1'b1, t_acc, waits);
    issue(16'h8000, 16'h0001, 1'b1, t_acc, waits);
    issue(16'h1234, 16'h1234, 1'b1, t_acc, waits);
    wait_idle();

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, t_acc, waits);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) timeout_fail("bp_out_valid");
    snap = {cout, ovf, sum};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_hold", {14'b0, cout, ovf, sum}, {14'b0, snap});
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    pops_before = n_pops;
    out_ready = 1'b1;
    issue(16'hABCD, 16'h1234, 1'b1, t_acc, waits);
    check("bp_single_transfer", 32'(n_pops - pops_before), 1);
    check("bp_accept_delay", 32'(waits), 1);
    wait_idle();

    // Reset while the third nibble is in flight.
    issue(16'h4321, 16'h1357, 1'b0, t_acc, waits);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_outputs", {15'b0, cout, ovf, sum}, 0);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_busy", 32'(busy), 0);
    repeat (8) begin
      @(negedge clk);
      check("abort_no_result", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    issue(16'h0001, 16'h0001, 1'b0, t_acc, waits);
    wait_idle();

    // Back-to-back random stream with fixed accept spacing.
    t_prev = 0;
    for (int k = 0; k < 200; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), t_acc, waits);
      if (k > 0) check("accept_interval", 32'((t_acc - t_prev) / 10), ACC_IV);
      t_prev = t_acc;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
